// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM state encoding and counter widths.
package pipe_ctrl_pkg;

  localparam int PIPE_STATE_WIDTH = 2;
  localparam int BOOT_CNT_W       = 16;
  localparam int HOLD_CNT_W       = 16;

  typedef enum logic [PIPE_STATE_WIDTH-1:0] {
    PIPE_BOOT       = 2'd0,
    PIPE_RUN        = 2'd1,
    PIPE_TRAP_HOLD  = 2'd2,
    PIPE_TRAP_REDIR = 2'd3
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline controller signal bundle; the controller side is the master modport.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  // Level-qualified signals, no ready/valid handshake: clint_int_addr is only meaningful
  // while clint_int_assert=1, br_target_ex only while br_taken_ex=1, and redirect_pc only
  // while redirect_valid=1 (it reads 0 otherwise).
  logic        br_taken_ex;
  logic [31:0] br_target_ex;
  logic        clint_int_assert;
  logic [31:0] clint_int_addr;
  logic        clint_hold;
  logic        mem_busy;
  logic        hold_flag_if;
  logic        hold_flag_id;
  logic        hold_flag_ex;
  logic        br_taken;
  logic        flush_ex;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        hold_timeout_err;
  logic [31:0] stall_cnt;
  pipe_state_e dbg_state;

  modport master (
    input  br_taken_ex, br_target_ex, clint_int_assert, clint_int_addr, clint_hold, mem_busy,
    output hold_flag_if, hold_flag_id, hold_flag_ex, br_taken, flush_ex,
    output redirect_valid, redirect_pc, hold_timeout_err, stall_cnt, dbg_state
  );

  modport slave (
    output br_taken_ex, br_target_ex, clint_int_assert, clint_int_addr, clint_hold, mem_busy,
    input  hold_flag_if, hold_flag_id, hold_flag_ex, br_taken, flush_ex,
    input  redirect_valid, redirect_pc, hold_timeout_err, stall_cnt, dbg_state
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// 32-bit saturating incrementer with enable; sticks at all-ones.
module sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != 32'hFFFF_FFFF)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: boot hold, branch redirect, RAM stall and trap sequencing,
// plus a trap-hold watchdog and a stall cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          BOOT_HOLD_CYCLES = 4,
  parameter int          HOLD_TIMEOUT     = 255
) (
  input logic         clk,
  input logic         rst_n,
  pipe_ctrl_if.master bus
);

  pipe_state_e            r_state;
  pipe_state_e            w_state_nxt;
  logic [BOOT_CNT_W-1:0]  r_boot_cnt;
  logic [HOLD_CNT_W-1:0]  r_hold_cnt;
  logic [HOLD_CNT_W-1:0]  w_hold_cnt_inc;
  logic [31:0]            r_trap_pc_q;
  logic                   r_timeout_err;
  logic                   w_boot_last;
  logic                   w_hold_expired;
  logic                   w_trap_take;
  logic                   w_hold_if;
  logic                   w_hold_id;
  logic                   w_hold_ex;
  logic                   w_br_taken;
  logic                   w_flush_ex;
  logic                   w_redir_valid;
  logic [31:0]            w_redir_pc;
  logic [31:0]            w_stall_cnt;

  assign w_boot_last    = (r_boot_cnt == BOOT_CNT_W'(BOOT_HOLD_CYCLES - 1));
  // hold_cnt+1 is the number of TRAP_HOLD cycles including the current one.
  assign w_hold_cnt_inc = r_hold_cnt + HOLD_CNT_W'(1);
  assign w_hold_expired = (w_hold_cnt_inc == HOLD_CNT_W'(HOLD_TIMEOUT));
  assign w_trap_take    = (r_state == PIPE_RUN) && bus.clint_int_assert;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PIPE_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PIPE_BOOT:       if (w_boot_last) w_state_nxt = PIPE_RUN;
      PIPE_RUN:        if (bus.clint_int_assert)
                         w_state_nxt = bus.clint_hold ? PIPE_TRAP_HOLD : PIPE_TRAP_REDIR;
      PIPE_TRAP_HOLD:  if (!bus.clint_hold || w_hold_expired) w_state_nxt = PIPE_TRAP_REDIR;
      PIPE_TRAP_REDIR: w_state_nxt = PIPE_RUN;
      default:         w_state_nxt = PIPE_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_boot_cnt    <= '0;
      r_hold_cnt    <= '0;
      r_trap_pc_q   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == PIPE_BOOT) r_boot_cnt <= r_boot_cnt + BOOT_CNT_W'(1);
      if (w_trap_take) begin
        r_trap_pc_q <= bus.clint_int_addr;
        r_hold_cnt  <= '0;
      end else if (r_state == PIPE_TRAP_HOLD) begin
        r_hold_cnt <= w_hold_cnt_inc;
      end
      // Only a forced exit (clint still busy) counts as a watchdog event.
      if ((r_state == PIPE_TRAP_HOLD) && bus.clint_hold && w_hold_expired) r_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    w_hold_if     = 1'b0;
    w_hold_id     = 1'b0;
    w_hold_ex     = 1'b0;
    w_br_taken    = 1'b0;
    w_flush_ex    = 1'b0;
    w_redir_valid = 1'b0;
    w_redir_pc    = '0;
    if (!rst_n) begin
      w_hold_if = 1'b1;
      w_hold_id = 1'b1;
    end else begin
      case (r_state)
        PIPE_BOOT: begin
          w_hold_if = 1'b1;
          w_hold_id = 1'b1;
          if (w_boot_last) begin
            w_redir_valid = 1'b1;
            w_redir_pc    = RESET_PC;
            w_br_taken    = 1'b1;
            w_flush_ex    = 1'b1;
          end
        end
        PIPE_RUN: begin
          if (bus.clint_int_assert) begin
            w_hold_if  = 1'b1;
            w_hold_id  = 1'b1;
            w_flush_ex = 1'b1;
          end else if (bus.mem_busy) begin
            w_hold_if = 1'b1;
            w_hold_id = 1'b1;
            w_hold_ex = 1'b1;
          end else if (bus.br_taken_ex) begin
            w_redir_valid = 1'b1;
            w_redir_pc    = bus.br_target_ex;
            w_br_taken    = 1'b1;
            w_flush_ex    = 1'b1;
          end
        end
        PIPE_TRAP_HOLD: begin
          w_hold_if = 1'b1;
          w_hold_id = 1'b1;
        end
        PIPE_TRAP_REDIR: begin
          w_redir_valid = 1'b1;
          w_redir_pc    = r_trap_pc_q;
          w_br_taken    = 1'b1;
          w_flush_ex    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  sat_counter u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_hold_if),
    .o_cnt (w_stall_cnt)
  );

  assign bus.hold_flag_if     = w_hold_if;
  assign bus.hold_flag_id     = w_hold_id;
  assign bus.hold_flag_ex     = w_hold_ex;
  assign bus.br_taken         = w_br_taken;
  assign bus.flush_ex         = w_flush_ex;
  assign bus.redirect_valid   = w_redir_valid;
  assign bus.redirect_pc      = w_redir_pc;
  assign bus.hold_timeout_err = r_timeout_err;
  assign bus.stall_cnt        = w_stall_cnt;
  assign bus.dbg_state        = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int BOOT_N = 4;
  localparam int TMO    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.RESET_PC(RESET_PC), .BOOT_HOLD_CYCLES(BOOT_N), .HOLD_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_boot_seen;
  bit          m_booting;
  bit          m_waiting;
  int          m_wait_seen;
  bit          m_redir_due;
  logic [31:0] m_vec;
  bit          m_err;
  logic [31:0] m_stall;
  logic [5:0]  e_flags;   // {if, id, ex, br_taken, flush_ex, redirect_valid}
  logic [31:0] e_pc;
  logic [31:0] exp_q[$];  // redirect targets still to be seen

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_boot_seen = 0;
    m_booting   = 1'b1;
    m_waiting   = 1'b0;
    m_wait_seen = 0;
    m_redir_due = 1'b0;
    m_vec       = '0;
    m_err       = 1'b0;
    m_stall     = '0;
  endtask

  task automatic model_outputs();
    e_flags = '0;
    e_pc    = '0;
    if (m_booting) begin
      e_flags = 6'b110000;
      if (m_boot_seen == BOOT_N - 1) begin
        e_flags = 6'b110111;
        e_pc    = RESET_PC;
      end
    end else if (m_redir_due) begin
      e_flags = 6'b000111;
      e_pc    = m_vec;
    end else if (m_waiting) begin
      e_flags = 6'b110000;
    end else if (bus.clint_int_assert) begin
      e_flags = 6'b110010;
    end else if (bus.mem_busy) begin
      e_flags = 6'b111000;
    end else if (bus.br_taken_ex) begin
      e_flags = 6'b000111;
      e_pc    = bus.br_target_ex;
    end
  endtask

  task automatic model_advance();
    if (e_flags[5] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (m_booting) begin
      m_boot_seen++;
      if (m_boot_seen == BOOT_N) m_booting = 1'b0;
    end else if (m_redir_due) begin
      m_redir_due = 1'b0;
    end else if (m_waiting) begin
      m_wait_seen++;
      if (!bus.clint_hold) begin
        m_waiting = 1'b0; m_redir_due = 1'b1;
      end else if (m_wait_seen == TMO) begin
        m_waiting = 1'b0; m_redir_due = 1'b1; m_err = 1'b1;
      end
    end else if (bus.clint_int_assert) begin
      m_vec = bus.clint_int_addr;
      if (bus.clint_hold) begin
        m_waiting = 1'b1; m_wait_seen = 0;
      end else begin
        m_redir_due = 1'b1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit intr, input logic [31:0] addr, input bit chold,
                       input bit mbusy, input bit br, input logic [31:0] tgt);
    bus.clint_int_assert = intr;
    bus.clint_int_addr   = addr;
    bus.clint_hold       = chold;
    bus.mem_busy         = mbusy;
    bus.br_taken_ex      = br;
    bus.br_target_ex     = tgt;
  endtask

  // One clock: inputs already driven at posedge+1; check at +3, then advance the model at the edge.
  task automatic run_cycle();
    #2;
    model_outputs();
    if (e_flags[0]) exp_q.push_back(e_pc);
    check("flags", 32'({bus.hold_flag_if, bus.hold_flag_id, bus.hold_flag_ex,
                        bus.br_taken, bus.flush_ex, bus.redirect_valid}), 32'(e_flags));
    check("redirect_pc", bus.redirect_pc, e_pc);
    check("stall_cnt", bus.stall_cnt, m_stall);
    check("timeout_err", 32'(bus.hold_timeout_err), 32'(m_err));
    if (bus.redirect_valid === 1'b1) begin
      if (exp_q.size() == 0) check("redir_unexpected", 32'd1, 32'd0);
      else check("redir_target", bus.redirect_pc, exp_q.pop_front());
    end
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      run_cycle();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, 32'({bus.hold_flag_if, bus.hold_flag_id, bus.hold_flag_ex,
                                bus.br_taken, bus.flush_ex, bus.redirect_valid}), 32'b110000);
    check({tag, "_pc"}, bus.redirect_pc, 32'h0);
    check({tag, "_stall"}, bus.stall_cnt, 32'h0);
    check({tag, "_err"}, 32'(bus.hold_timeout_err), 32'h0);
    check({tag, "_state"}, 32'(bus.dbg_state), 32'(PIPE_BOOT));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    @(posedge clk);
    #3;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Boot window; a clint pulse inside it must be ignored.
    idle(1);
    drive(1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    run_cycle();
    idle(2);
    idle(1);  // first RUN cycle, stall_cnt expected 4

    // Branch redirect in RUN.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    run_cycle();

    // Branch held back by a 3-cycle RAM stall, then taken.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0180);
      run_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0180);
    run_cycle();

    // Trap without CSR wait; simultaneous branch to 0x200 dropped.
    drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    run_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
    run_cycle();
    idle(1);

    // Trap with CSR wait: 5 TRAP_HOLD cycles.
    drive(1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 32'h0);
    run_cycle();
    for (int k = 0; k < 5; k++) begin
      drive(k == 2, 32'h0000_0999, (k < 4), 1'b0, 1'b0, 32'h0);
      run_cycle();
    end
    idle(2);

    // Watchdog: clint_hold stuck high.
    drive(1'b1, 32'h0000_00C0, 1'b1, 1'b0, 1'b0, 32'h0);
    run_cycle();
    for (int k = 0; k < TMO + 2; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      run_cycle();
    end
    idle(2);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 9) == 0), $urandom, $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), $urandom);
      run_cycle();
    end

    // Asynchronous reset in the middle of TRAP_HOLD.
    idle(1);
    drive(1'b1, 32'h0000_0400, 1'b1, 1'b0, 1'b0, 32'h0);
    if (!m_booting && !m_waiting && !m_redir_due) begin
      run_cycle();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      run_cycle();
      check("in_trap_hold", 32'(bus.dbg_state), 32'(PIPE_TRAP_HOLD));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(BOOT_N + 2);

    check("redir_queue_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
